// File: rtl/move_arbiter.sv
// move_arbiter: serializes grid-move requests from N movers.
// Each request looks up its target tile in the synchronous map ROM.
// It also compares the target against the positions of the other live entities.
// The mover then gets a single-cycle accept carrying either the requested cell
// (if free) or its own current cell (null move).
module move_arbiter #(
    parameter int         N    = 4,
    parameter logic [1:0] WALL = 2'b01
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     ask_move,
    input  logic [4*N-1:0]   ask_x,
    input  logic [4*N-1:0]   ask_y,
    input  logic [4*N-1:0]   cur_x,
    input  logic [4*N-1:0]   cur_y,
    input  logic [N-1:0]     ent_valid,
    input  logic             freeze,
    output logic [7:0]       map_addr,
    input  logic [1:0]       map_rdata,
    output logic [N-1:0]     accept_move,
    output logic [3:0]       goto_x,
    output logic [3:0]       goto_y,
    output logic             busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DECIDE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    pending;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   sel_q;
    logic [3:0]      tx;
    logic [3:0]      ty;

    logic [PW-1:0]   pick;
    logic            pick_valid;
    int              pick_idx;
    logic [N-1:0]    sel_onehot;
    logic [N-1:0]    grant_clear;
    logic            occupied;
    logic            blocked;
    logic [3:0]      pick_x;
    logic [3:0]      pick_y;
    logic [3:0]      own_x;
    logic [3:0]      own_y;

    // Round-robin pick: the first pending requester at or after rr_ptr, wrapping.
    // Scanning from the far end down lets the nearest candidate overwrite the others.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        pick_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pick_idx = int'(rr_ptr) + k;
            if (pick_idx >= N) begin
                pick_idx = pick_idx - N;
            end
            if (pending[pick_idx]) begin
                pick       = PW'(pick_idx);
                pick_valid = 1'b1;
            end
        end
    end

    // Coordinates requested by the candidate, and the current cell of the
    // requester being decided (used for a null move).
    always_comb begin
        pick_x = ask_x[4*int'(pick) +: 4];
        pick_y = ask_y[4*int'(pick) +: 4];
        own_x  = cur_x[4*int'(sel_q) +: 4];
        own_y  = cur_y[4*int'(sel_q) +: 4];
    end

    // Another live entity standing on the target cell blocks the move.
    // The requester itself never blocks its own move.
    always_comb begin
        occupied = 1'b0;
        for (int j = 0; j < N; j++) begin
            if ((j != int'(sel_q)) && ent_valid[j] &&
                (cur_x[4*j +: 4] == tx) && (cur_y[4*j +: 4] == ty)) begin
                occupied = 1'b1;
            end
        end
        blocked = (map_rdata == WALL) || occupied;
    end

    // The grant one-hot doubles as the pending-clear mask on the DECIDE edge.
    always_comb begin
        sel_onehot  = N'(1) << sel_q;
        grant_clear = (state == DECIDE) ? sel_onehot : '0;
    end

    // A new ask always lands in pending, even on the edge that grants the same
    // requester, so a late re-ask is never lost. Repeated asks merge into one bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant_clear) | ask_move;
        end
    end

    // Arbitration FSM: select and address the ROM, wait one cycle for the tile,
    // then decide and issue the one-cycle accept. All outputs are registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            sel_q       <= '0;
            tx          <= '0;
            ty          <= '0;
            map_addr    <= '0;
            accept_move <= '0;
            goto_x      <= '0;
            goto_y      <= '0;
            busy        <= 1'b0;
        end else begin
            accept_move <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid && !freeze) begin
                        sel_q    <= pick;
                        tx       <= pick_x;
                        ty       <= pick_y;
                        map_addr <= {pick_y, pick_x};
                        state    <= READ;
                        busy     <= 1'b1;
                    end
                end
                READ: begin
                    state <= DECIDE;
                end
                DECIDE: begin
                    accept_move <= sel_onehot;
                    if (blocked) begin
                        goto_x <= own_x;
                        goto_y <= own_y;
                    end else begin
                        goto_x <= tx;
                        goto_y <= ty;
                    end
                    if (int'(sel_q) == N - 1) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= sel_q + PW'(1);
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_arbiter.sv
// tb_move_arbiter: directed bench for move_arbiter.
// A transaction-level model predicts every accept, goto, map_addr and busy
// value on each cycle. Hand-computed expectations pin the key scenarios.
module tb_move_arbiter;

    localparam int         N    = 4;
    localparam logic [1:0] WALL = 2'b01;

    logic           clk;
    logic           rstn;
    logic [N-1:0]   ask_move;
    logic [4*N-1:0] ask_x;
    logic [4*N-1:0] ask_y;
    logic [4*N-1:0] cur_x;
    logic [4*N-1:0] cur_y;
    logic [N-1:0]   ent_valid;
    logic           freeze;
    logic [7:0]     map_addr;
    logic [1:0]     map_rdata;
    logic [N-1:0]   accept_move;
    logic [3:0]     goto_x;
    logic [3:0]     goto_y;
    logic           busy;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    logic [1:0] rom [256];

    move_arbiter #(.N(N), .WALL(WALL)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ask_move   (ask_move),
        .ask_x      (ask_x),
        .ask_y      (ask_y),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .ent_valid  (ent_valid),
        .freeze     (freeze),
        .map_addr   (map_addr),
        .map_rdata  (map_rdata),
        .accept_move(accept_move),
        .goto_x     (goto_x),
        .goto_y     (goto_y),
        .busy       (busy)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous map ROM: the tile appears the cycle after the address is sampled.
    always @(posedge clk) map_rdata <= rom[map_addr];

    // Transaction-level model state.
    logic [N-1:0] m_pending;
    int           m_stage;
    int           m_sel;
    int           m_rr;
    logic [3:0]   m_tx, m_ty;
    logic         m_blocked;
    logic [N-1:0] exp_accept;
    logic [3:0]   exp_gx, exp_gy;
    logic [7:0]   exp_addr;

    // Model: at most one transaction in flight, three edges from selection to grant.
    // The target is free unless it is a wall or another live entity stands on it.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pending  = '0;
            m_stage    = 0;
            m_sel      = 0;
            m_rr       = 0;
            m_tx       = '0;
            m_ty       = '0;
            exp_accept = '0;
            exp_gx     = '0;
            exp_gy     = '0;
            exp_addr   = '0;
        end else begin
            exp_accept = '0;
            if (m_stage == 2) begin
                m_blocked = (rom[{m_ty, m_tx}] == WALL);
                for (int j = 0; j < N; j++) begin
                    if (j != m_sel && ent_valid[j] &&
                        cur_x[4*j +: 4] == m_tx && cur_y[4*j +: 4] == m_ty)
                        m_blocked = 1'b1;
                end
                exp_accept[m_sel] = 1'b1;
                exp_gx = m_blocked ? cur_x[4*m_sel +: 4] : m_tx;
                exp_gy = m_blocked ? cur_y[4*m_sel +: 4] : m_ty;
                m_pending[m_sel] = 1'b0;
                m_rr    = (m_sel + 1) % N;
                m_stage = 0;
            end else if (m_stage == 1) begin
                m_stage = 2;
            end else if (m_pending != 0 && !freeze) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (m_pending[(m_rr + k) % N]) m_sel = (m_rr + k) % N;
                end
                m_tx     = ask_x[4*m_sel +: 4];
                m_ty     = ask_y[4*m_sel +: 4];
                exp_addr = {m_ty, m_tx};
                m_stage  = 1;
            end
            m_pending = m_pending | ask_move;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle compare the DUT against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("model accept", 32'(accept_move), 32'(exp_accept));
            check_output("model busy", 32'(busy), 32'(m_stage != 0));
            check_output("model map_addr", 32'(map_addr), 32'(exp_addr));
            if (exp_accept != 0) begin
                check_output("model goto_x", 32'(goto_x), 32'(exp_gx));
                check_output("model goto_y", 32'(goto_y), 32'(exp_gy));
            end
        end
    end

    task automatic set_ask(input int i, input logic [3:0] x, input logic [3:0] y);
        ask_x[4*i +: 4] = x;
        ask_y[4*i +: 4] = y;
    endtask

    task automatic set_cur(input int i, input logic [3:0] x, input logic [3:0] y);
        cur_x[4*i +: 4] = x;
        cur_y[4*i +: 4] = y;
    endtask

    // Pulse ask_move for one edge; returns at the negedge after that edge.
    task automatic apply_stimulus(input logic [N-1:0] mask);
        ask_move = mask;
        @(posedge clk);
        @(negedge clk);
        ask_move = '0;
    endtask

    // Expect silence for edges-1 cycles, then the given grant.
    task automatic expect_grant(input string name, input int edges, input logic [N-1:0] onehot,
                                input logic [3:0] gx, input logic [3:0] gy);
        for (int e = 1; e < edges; e++) begin
            @(negedge clk);
            check_output({name, " early"}, 32'(accept_move), 32'h0);
        end
        @(negedge clk);
        check_output({name, " accept"}, 32'(accept_move), 32'(onehot));
        check_output({name, " goto_x"}, 32'(goto_x), 32'(gx));
        check_output({name, " goto_y"}, 32'(goto_y), 32'(gy));
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, " accept"}, 32'(accept_move), 32'h0);
        check_output({name, " goto_x"}, 32'(goto_x), 32'h0);
        check_output({name, " goto_y"}, 32'(goto_y), 32'h0);
        check_output({name, " map_addr"}, 32'(map_addr), 32'h0);
        check_output({name, " busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int seen;
        for (int a = 0; a < 256; a++) rom[a] = 2'b00;
        rom[8'hB7] = WALL;

        rstn      = 1'b0;
        ask_move  = '0;
        freeze    = 1'b0;
        ent_valid = 4'b1111;
        ask_x     = '0;
        ask_y     = '0;
        cur_x     = '0;
        cur_y     = '0;
        set_cur(0, 4'd6, 4'd11);
        set_cur(1, 4'd1, 4'd1);
        set_cur(2, 4'd2, 4'd2);
        set_cur(3, 4'd3, 4'd3);
        set_ask(0, 4'd6, 4'd10);
        set_ask(1, 4'd9, 4'd9);
        set_ask(2, 4'd10, 4'd10);
        set_ask(3, 4'd11, 4'd11);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #2 rstn = 1'b1;
        check_en = 1'b1;
        @(negedge clk);

        $display("[TB] single free move");
        apply_stimulus(4'b0001);
        @(negedge clk);
        check_output("free early", 32'(accept_move), 32'h0);
        check_output("free map_addr", 32'(map_addr), 32'hA6);
        check_output("free busy", 32'(busy), 32'h1);
        expect_grant("free", 2, 4'b0001, 4'd6, 4'd10);
        @(negedge clk);
        check_output("free one cycle", 32'(accept_move), 32'h0);

        $display("[TB] wall");
        set_ask(0, 4'd7, 4'd11);
        apply_stimulus(4'b0001);
        expect_grant("wall", 3, 4'b0001, 4'd6, 4'd11);

        $display("[TB] entity collision");
        set_cur(1, 4'd5, 4'd5);
        set_ask(0, 4'd5, 4'd5);
        @(negedge clk);
        apply_stimulus(4'b0001);
        expect_grant("collide", 3, 4'b0001, 4'd6, 4'd11);
        ent_valid = 4'b1101;
        @(negedge clk);
        apply_stimulus(4'b0001);
        expect_grant("dead entity", 3, 4'b0001, 4'd5, 4'd5);

        $display("[TB] duplicate ask absorbed");
        ent_valid = 4'b1111;
        set_cur(1, 4'd1, 4'd1);
        set_ask(0, 4'd4, 4'd12);
        @(negedge clk);
        apply_stimulus(4'b0001);
        apply_stimulus(4'b0001);
        expect_grant("dup", 2, 4'b0001, 4'd4, 4'd12);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (accept_move != 0) seen++;
        end
        check_output("dup absorbed", 32'(seen), 32'h0);

        $display("[TB] round robin");
        #2 rstn = 1'b0;
        #1 check_reset_outputs("rr reset");
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        set_ask(0, 4'd8, 4'd8);
        apply_stimulus(4'b1111);
        expect_grant("rr g0", 3, 4'b0001, 4'd8, 4'd8);
        expect_grant("rr g1", 3, 4'b0010, 4'd9, 4'd9);
        expect_grant("rr g2", 3, 4'b0100, 4'd10, 4'd10);
        expect_grant("rr g3", 3, 4'b1000, 4'd11, 4'd11);
        apply_stimulus(4'b0110);
        apply_stimulus(4'b0001);
        expect_grant("rr2 g1", 2, 4'b0010, 4'd9, 4'd9);
        expect_grant("rr2 g2", 3, 4'b0100, 4'd10, 4'd10);
        expect_grant("rr2 g0", 3, 4'b0001, 4'd8, 4'd8);

        $display("[TB] freeze");
        @(negedge clk);
        freeze = 1'b1;
        apply_stimulus(4'b0100);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_output("freeze accept", 32'(accept_move), 32'h0);
            check_output("freeze busy", 32'(busy), 32'h0);
        end
        freeze = 1'b0;
        expect_grant("unfreeze", 3, 4'b0100, 4'd10, 4'd10);

        $display("[TB] reset mid-operation");
        @(negedge clk);
        apply_stimulus(4'b1000);
        @(negedge clk);
        check_output("midrst busy", 32'(busy), 32'h1);
        check_output("midrst map_addr", 32'(map_addr), 32'hBB);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_output("midrst no accept", 32'(accept_move), 32'h0);
            check_output("midrst idle", 32'(busy), 32'h0);
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
